// File: rtl/scan_decoder_pkg.sv
// ============================================================================
// scan_decoder_pkg
// ----------------------------------------------------------------------------
// Purpose : Shared types, constants and helpers for the scan_decoder block.
//           - scanState_e : controller state encoding (IDLE, DIRECT, SCAN)
//           - MIN_DWELL   : smallest legal dwell time in cycles
//           - MAX_SEL_W   : widest select the onehot() helper supports
//           - onehot()    : binary index to one-hot vector, MAX_OUT_W bits wide;
//                           callers cast the result down to their own width
// Ports   : none (package)
// ============================================================================
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } scanState_e;

    localparam int MIN_DWELL = 1;
    localparam int MAX_DWELL = 65535;
    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

    // The package cannot see the decoder's SEL_W, so the helper works at the
    // widest supported size and callers truncate with a size cast.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        onehot = MAX_OUT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/scan_decoder_dwell_counter.sv
// ============================================================================
// scan_dwell_counter
// ----------------------------------------------------------------------------
// Purpose : Counts the cycles a scan position has been held and flags the
//           last one. The count restarts from zero whenever clr is high.
// Params  : DWELL - cycles per position (1..65535)
// Ports   : clk   in  rising-edge clock
//           reset in  synchronous, active-high reset (count -> 0)
//           clr   in  force the count back to zero (wins over run)
//           run   in  advance the count this cycle
//           tick  out high on the last dwell cycle while running
// ============================================================================
module scan_dwell_counter
    import scan_decoder_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = $clog2(DWELL) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear has priority, otherwise roll over at LAST so the
    // counter never leaves 0..DWELL-1. With DWELL=1 LAST is zero and tick
    // fires on every running cycle.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (run) begin
            count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
        end
    end

    // Tick is combinational so the controller can step the index on the
    // same edge that the counter rolls over.
    always_comb begin
        tick = run && !clr && (count_q == LAST);
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// ============================================================================
// scan_decoder
// ----------------------------------------------------------------------------
// Purpose : Registered binary-to-one-hot decoder with enable and an
//           autonomous scan mode that sweeps the one-hot output through every
//           position, holding each for DWELL cycles (row/digit scanning of
//           LED and keypad matrices).
// Params  : SEL_W - select width (output width OUT_W = 2**SEL_W, derived)
//           DWELL - cycles each position is held in scan mode (1..65535)
// Ports   : clk   in  rising-edge clock
//           reset in  synchronous, active-high reset
//           en    in  enable; low forces y to zero
//           mode  in  0 = direct decode, 1 = scan
//           sel   in  direct-mode select / scan start position
//           y     out registered one-hot output (zero when idle or blank)
//           idx   out registered index currently decoded
//           wrap  out one-cycle pulse when the scan index wraps to 0
//           busy  out high while scanning
// Macro   : SCAN_DECODER_BLANK_EN - when defined, every scan advance inserts
//           one all-zero cycle before the new position is driven.
// ============================================================================
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter  int SEL_W = 3,
    parameter  int DWELL = 4,
    localparam int OUT_W = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] y,
    output logic [SEL_W-1:0] idx,
    output logic             wrap,
    output logic             busy
);

    if (DWELL < MIN_DWELL || DWELL > MAX_DWELL) begin : gBadDwell
        $error("scan_decoder: DWELL out of range 1..65535");
    end
    if (SEL_W < 1 || SEL_W > MAX_SEL_W) begin : gBadSelW
        $error("scan_decoder: SEL_W out of supported range");
    end

    scanState_e       state_q, state_d;
    logic [OUT_W-1:0] y_q, y_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             wrap_q, wrap_d;
    logic             busy_q, busy_d;
    logic [SEL_W-1:0] nextIdx;
    logic             dwellRun;
    logic             dwellClr;
    logic             dwellTick;
`ifdef SCAN_DECODER_BLANK_EN
    logic             blank_q, blank_d;
`endif

    scan_dwell_counter #(
        .DWELL (DWELL)
    ) uDwell (
        .clk   (clk),
        .reset (reset),
        .clr   (dwellClr),
        .run   (dwellRun),
        .tick  (dwellTick)
    );

    // Index of the next scan position. Kept as its own SEL_W-wide signal so
    // the increment wraps modulo OUT_W before it is widened for onehot().
    always_comb begin
        nextIdx = idx_q + SEL_W'(1);
    end

    // Next-state and output logic. The target state comes straight from
    // en/mode each cycle; the registered outputs are then computed for that
    // target. Scan entry (previous state not SCAN) loads sel and restarts
    // the dwell counter, so re-entering scan never resumes an old sweep.
    // In steady scan the dwell counter runs and its tick steps the index;
    // wrap is raised only on the step from OUT_W-1 to 0. In the blanking
    // build the step first emits an all-zero cycle (idx and wrap already
    // updated), and the counter is held clear during that blank so the new
    // position still gets a full DWELL cycles.
    always_comb begin
        state_d  = en ? (mode ? SCAN : DIRECT) : IDLE;
        y_d      = '0;
        idx_d    = idx_q;
        wrap_d   = 1'b0;
        busy_d   = 1'b0;
        dwellRun = 1'b0;
        dwellClr = 1'b1;
`ifdef SCAN_DECODER_BLANK_EN
        blank_d  = 1'b0;
`endif
        unique case (state_d)
            IDLE: begin
            end
            DIRECT: begin
                y_d   = OUT_W'(onehot(MAX_SEL_W'(sel)));
                idx_d = sel;
            end
            SCAN: begin
                busy_d = 1'b1;
                if (state_q != SCAN) begin
                    y_d   = OUT_W'(onehot(MAX_SEL_W'(sel)));
                    idx_d = sel;
`ifdef SCAN_DECODER_BLANK_EN
                end else if (blank_q) begin
                    y_d = OUT_W'(onehot(MAX_SEL_W'(idx_q)));
                end else begin
                    dwellRun = 1'b1;
                    dwellClr = 1'b0;
                    if (dwellTick) begin
                        idx_d   = nextIdx;
                        wrap_d  = &idx_q;
                        y_d     = '0;
                        blank_d = 1'b1;
                    end else begin
                        y_d = y_q;
                    end
                end
`else
                end else begin
                    dwellRun = 1'b1;
                    dwellClr = 1'b0;
                    if (dwellTick) begin
                        idx_d  = nextIdx;
                        wrap_d = &idx_q;
                        y_d    = OUT_W'(onehot(MAX_SEL_W'(nextIdx)));
                    end else begin
                        y_d = y_q;
                    end
                end
`endif
            end
            default: begin
            end
        endcase
    end

    // State and output registers. Reset wins over every input, including
    // in the middle of a sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            y_q     <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SCAN_DECODER_BLANK_EN
            blank_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
`ifdef SCAN_DECODER_BLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

    // All outputs come directly from flops.
    always_comb begin
        y    = y_q;
        idx  = idx_q;
        wrap = wrap_q;
        busy = busy_q;
    end

endmodule

// File: tb/tb_scan_decoder.sv
// ============================================================================
// tb_scan_decoder
// ----------------------------------------------------------------------------
// Purpose : Self-checking bench for scan_decoder (SEL_W=3, DWELL=2).
//           Stimulus pushes the expected registered response for the next
//           cycle into a queue; an independent monitor on the falling edge
//           pops and compares entries whose cycle has arrived, and checks
//           that y is never multi-hot. Honours SCAN_DECODER_BLANK_EN.
// Ports   : none (top-level bench)
// ============================================================================
module tb_scan_decoder;

    localparam int SEL_W = 3;
    localparam int DWELL = 2;

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] y;
        logic [2:0] idx;
        logic       wrap;
        logic       busy;
    } expect_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       mode;
    logic [2:0] sel;
    logic [7:0] y;
    logic [2:0] idx;
    logic       wrap;
    logic       busy;

    expect_t    sbQ[$];
    expect_t    monItem;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    bit         countWraps = 1'b0;
    int         wrapCount = 0;

    logic [7:0] scanY[6];
    logic [2:0] scanIdx[6];
    logic       scanWrap[6];
    logic [2:0] heldIdx;
    int         expWraps;

    scan_decoder #(
        .SEL_W (SEL_W),
        .DWELL (DWELL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .y     (y),
        .idx   (idx),
        .wrap  (wrap),
        .busy  (busy)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Cycle stamp used to line expectations up with register updates.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Drive one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input logic r, input logic e, input logic m,
                                 input logic [2:0] s);
        @(posedge clk);
        #1;
        reset = r;
        en    = e;
        mode  = m;
        sel   = s;
    endtask

    // Queue the response expected after the next rising edge.
    task automatic pushExpect(input string n, input logic [7:0] ey,
                              input logic [2:0] ei, input logic ew,
                              input logic eb);
        expect_t t;
        t.cyc  = cyc + 1;
        t.name = n;
        t.y    = ey;
        t.idx  = ei;
        t.wrap = ew;
        t.busy = eb;
        sbQ.push_back(t);
    endtask

    // Compare the live outputs against one scoreboard entry.
    task automatic checkOutput(input expect_t t);
        checks++;
        if (y !== t.y || idx !== t.idx || wrap !== t.wrap || busy !== t.busy) begin
            errors++;
            $display("[TB] FAIL %s: got y=%h idx=%0d wrap=%b busy=%b, want y=%h idx=%0d wrap=%b busy=%b",
                     t.name, y, idx, wrap, busy, t.y, t.idx, t.wrap, t.busy);
        end
    endtask

    // Monitor: one-hot invariant every cycle, wrap counting window, and
    // scoreboard pops for every entry whose cycle has come up.
    always @(negedge clk) begin
        if (cyc > 1) begin
            checks++;
            if (!$onehot0(y)) begin
                errors++;
                $display("[TB] FAIL onehot at cycle %0d: got y=%h, want at most one bit set", cyc, y);
            end
        end
        if (countWraps && wrap) begin
            wrapCount++;
        end
        while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
            monItem = sbQ.pop_front();
            if (monItem.cyc < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s: sampled at cycle %0d, required cycle %0d",
                         monItem.name, cyc, monItem.cyc);
            end else begin
                checkOutput(monItem);
            end
        end
    end

    initial begin
`ifdef SCAN_DECODER_BLANK_EN
        scanY    = '{8'h40, 8'h00, 8'h80, 8'h80, 8'h00, 8'h01};
        scanIdx  = '{3'd6, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0};
        scanWrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        heldIdx  = 3'd0;
        expWraps = 3;
`else
        scanY    = '{8'h40, 8'h80, 8'h80, 8'h01, 8'h01, 8'h02};
        scanIdx  = '{3'd6, 3'd7, 3'd7, 3'd0, 3'd0, 3'd1};
        scanWrap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        heldIdx  = 3'd1;
        expWraps = 4;
`endif
        reset = 1'b1;
        en    = 1'b0;
        mode  = 1'b0;
        sel   = 3'd0;

        // Power-on reset.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
        pushExpect("reset", 8'h00, 3'd0, 1'b0, 1'b0);

        // Reset in the middle of a scan at idx=5.
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd5);
        pushExpect("scan_entry_5", 8'h20, 3'd5, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd5);
        pushExpect("reset_mid_scan", 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd5);
        pushExpect("idle_after_reset", 8'h00, 3'd0, 1'b0, 1'b0);

        // Direct decode.
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd2);
        pushExpect("direct_sel2", 8'h04, 3'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd5);
        pushExpect("direct_sel5", 8'h20, 3'd5, 1'b0, 1'b0);

        // Disable: output blanks, idx holds.
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd6);
        pushExpect("disable_hold_idx", 8'h00, 3'd5, 1'b0, 1'b0);

        // Scan from 6 through the wrap; sel changes are ignored once scanning.
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd6);
        pushExpect("scan_entry_6", 8'h40, 3'd6, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 3'd0);
            pushExpect($sformatf("scan_step%0d", i), scanY[i], scanIdx[i], scanWrap[i], 1'b1);
        end

        // Mode switch mid-scan and restart from sel.
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
        pushExpect("idle_before_switch", 8'h00, heldIdx, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd7);
        pushExpect("scan_entry_7", 8'h80, 3'd7, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd1);
        pushExpect("switch_to_direct", 8'h02, 3'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd1);
        pushExpect("rescan_restart", 8'h02, 3'd1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd1);
        pushExpect("rescan_dwell", 8'h02, 3'd1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
        pushExpect("idle_before_sweep", 8'h00, 3'd1, 1'b0, 1'b0);

        // 64-cycle sweep starting at 7, counting wrap pulses.
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd7);
        pushExpect("sweep_entry", 8'h80, 3'd7, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        countWraps = 1'b1;
        repeat (64) @(negedge clk);
        #1;
        countWraps = 1'b0;

        checks++;
        if (wrapCount != expWraps) begin
            errors++;
            $display("[TB] FAIL sweep_wraps: got %0d wrap pulses, want %0d", wrapCount, expWraps);
        end

        // Let the monitor drain anything still queued, within a bound.
        for (int i = 0; i < 20 && sbQ.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (sbQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, want 0", sbQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
